obs_scroller: RTL
=================

# obs_scroller

Upstream feeder for `obs_rom`. Owns the on-screen obstacle slots and spawns new obstacles with pseudo-random type and spacing. On every frame tick it scrolls the slots left by the game speed. For every pixel presented by the video timing it produces the registered `{rom_y, rom_x}` sprite address and obstacle type that `obs_rom` turns into a colour bit.

## Interface
- `NUM_SLOTS`, 2: number of simultaneous obstacles; lower index wins on overlap.
- `SCREEN_W`, 640: visible width; the spawn x coordinate.
- `OBS_TOP`, 352: screen y of the sprite's top row.
- `SCALE_SHIFT`, 2: sprite magnification is 2^SCALE_SHIFT. `SPRITE_PIX` = 16 << SCALE_SHIFT.
- `MIN_GAP`, 40: minimum number of frames between spawn attempts.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `i_frame_tick`, in, 1: one-cycle pulse, once per frame, during blanking.
- `i_game_active`, in, 1: when low, scrolling and spawning freeze.
- `i_restart`, in, 1: one-cycle pulse; clears all slots.
- `i_speed`, in, 4: pixels moved per frame tick.
- `i_hpos`, in, 10: current pixel x.
- `i_vpos`, in, 10: current pixel y.
- `o_rom_counter`, out, 8: `{rom_y, rom_x}` sprite address for `obs_rom`.
- `o_obs_type`, out, 3: obstacle type code; `EMPTY` (000) when no obstacle covers the pixel.

## Operation
- **Slot state**
  - Each slot holds `valid`, signed 11-bit `x` (left edge), and a 3-bit `type`.
- **LFSR**
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Seed is 16'hACE1.
  - Advances once per accepted frame tick.
- **Accepted tick**
  - A tick is accepted when `i_frame_tick` is high, `i_game_active` is high, and `i_restart` is low.
- **Scrolling**, on each accepted tick:
  - Every valid slot updates `x <= x - i_speed`.
  - A slot whose new x is <= -SPRITE_PIX is cleared to invalid.
- **Spawn FSM**
  - `WAIT_GAP`: decrements the gap counter on each accepted tick. When the counter reaches 0, go to `SPAWN`.
  - `SPAWN`: on the next accepted tick, act on the lowest-index free slot:
    - If `lfsr[2:0]` != `EMPTY`, load that slot with `x = SCREEN_W` and `type = lfsr[2:0]`.
    - If `lfsr[2:0]` == `EMPTY`, spawn nothing.
    - Either way, reload the gap counter with `MIN_GAP + lfsr[7:3]` and return to `WAIT_GAP`.
    - If no slot is free, stay in `SPAWN`; the LFSR keeps advancing.
- **Ordering within one tick**
  - Movement and expiry are evaluated first, then the spawn.
  - A slot freed by expiry on this tick is eligible for the spawn.
  - A freshly spawned slot is not moved on its spawn tick.
- **Restart**
  - `i_restart` clears all slots, sets the gap counter to `MIN_GAP`, and enters `WAIT_GAP`.
  - The LFSR is not reseeded.
  - Restart has priority over a simultaneous frame tick.
- **Pixel lookup**
  - Slot i covers the pixel when `dx = i_hpos - x` is in [0, SPRITE_PIX) and `dy = i_vpos - OBS_TOP` is in [0, SPRITE_PIX).
  - `dx` and `dy` are computed signed at 12 bits.
  - The first covering slot, by lowest index, drives `o_rom_counter = {dy >> SCALE_SHIFT, dx >> SCALE_SHIFT}` (4 bits each) and `o_obs_type = type`.
  - When no slot covers the pixel, `o_rom_counter = 0` and `o_obs_type = EMPTY`.
  - Both outputs are registered.
- **Reset values**
  - Outputs: `o_rom_counter` = 0, `o_obs_type` = `EMPTY`.
  - Internal state: all slots invalid, LFSR = 16'hACE1, gap counter = `MIN_GAP`, FSM in `WAIT_GAP`.

## Timing
- Pixel path latency is 1 clock: the outputs for an `(i_hpos, i_vpos)` pair are valid on the cycle after it is presented.
- The downstream `obs_rom` is combinational, so the total sprite delay is 1 clock. The display stage compensates for it.
- Slot and FSM updates become visible on the cycle after the accepted tick.
- Reset is asynchronous assertion; de-assertion is synchronised externally.
- `i_speed` is sampled only on an accepted tick.
- x arithmetic wraps nowhere: 11-bit signed covers [-1024, 1023], and x never exceeds `SCREEN_W`.

## Structure
- Shared package `dino_pkg` holds:
  - the obstacle type constants (`EMPTY`, `CAC_3`, `CAC_2`, `CAC_THICK_1`, `CAC_THICK_2`, `CAC_THIN`, `BIRD_LOW`, `BIRD_HIGH`);
  - the screen geometry constants (`SCREEN_W`, `OBS_TOP`);
  - the sprite size (16).
- The LFSR is a separate sub-module, `obs_lfsr`: seed parameter, advance enable, 16-bit state output. The score and cloud blocks reuse it.

## Test plan
- **Reset:** release `rst_n` -> `o_obs_type` = 0 and `o_rom_counter` = 0 for every pixel; first spawn only after 41 accepted ticks (40 in `WAIT_GAP` plus 1 in `SPAWN`).
- **Scroll and lookup:** speed 4, `SCALE_SHIFT` 2, slot spawned at 640, then 10 ticks -> x = 600; pixel (605, `OBS_TOP` + 9) -> `o_rom_counter` = 8'h21 one cycle later, `o_obs_type` = the spawned type.
- **Expiry and reuse:** slot at x = -62 with speed 4 -> slot cleared on the tick; the same tick's spawn goes into that slot at x = 640 and is unmoved.
- **Slots full:** two valid slots and gap expired -> FSM holds in `SPAWN`; spawn happens on the tick one slot expires; the reloaded gap equals `MIN_GAP + lfsr[7:3]` per the bench LFSR model.
- **Freeze and restart:** `i_game_active` low for 5 ticks -> x unchanged and LFSR unchanged; `i_restart` coincident with `i_frame_tick` -> all slots invalid, no movement, gap counter = 40.
- **Overlap:** slots 0 and 1 both covering a pixel -> type and counter come from slot 0.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared game constants: obstacle type codes, screen geometry, sprite size,
// and the slot/FSM types used by the obstacle scroller.
package dino_pkg;

  typedef enum logic [2:0] {
    EMPTY       = 3'd0,
    CAC_3       = 3'd1,
    CAC_2       = 3'd2,
    CAC_THICK_1 = 3'd3,
    CAC_THICK_2 = 3'd4,
    CAC_THIN    = 3'd5,
    BIRD_LOW    = 3'd6,
    BIRD_HIGH   = 3'd7
  } obs_type_e;

  localparam int SCREEN_W    = 640;
  localparam int OBS_TOP     = 352;
  localparam int SPRITE_SIZE = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One on-screen obstacle: x is the signed left edge in screen pixels.
  typedef struct packed {
    logic              valid;
    logic signed [10:0] x;
    logic [2:0]        otype;
  } slot_t;

  typedef enum logic {
    WAIT_GAP = 1'b0,
    SPAWN    = 1'b1
  } spawn_state_e;

endpackage

// File: rtl/obs_lfsr.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, stepping when enabled.
module obs_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic [15:0] r_state;
  logic        w_fb;

  assign w_fb    = r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10];
  assign o_state = r_state;

  // Shift left, feedback enters at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_state <= SEED;
    else if (i_en)  r_state <= {r_state[14:0], w_fb};
  end

endmodule

// File: rtl/obs_scroller.sv
// Obstacle slot owner: scrolls slots per frame, spawns from the LFSR, and
// resolves each pixel to a registered sprite address and obstacle type.
module obs_scroller #(
  parameter int NUM_SLOTS   = 2,
  parameter int SCREEN_W    = dino_pkg::SCREEN_W,
  parameter int OBS_TOP     = dino_pkg::OBS_TOP,
  parameter int SCALE_SHIFT = 2,
  parameter int MIN_GAP     = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame_tick,
  input  logic       i_game_active,
  input  logic       i_restart,
  input  logic [3:0] i_speed,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  output logic [7:0] o_rom_counter,
  output logic [2:0] o_obs_type
);
  import dino_pkg::*;

  localparam int SPRITE_PIX = SPRITE_SIZE << SCALE_SHIFT;
  localparam int GAP_W      = $clog2(MIN_GAP + 32);
  localparam int IDX_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic signed [10:0] X_SPAWN = 11'(SCREEN_W);
  localparam logic signed [10:0] X_GONE  = 11'(-SPRITE_PIX);
  localparam logic signed [11:0] PIX12   = 12'(SPRITE_PIX);
  localparam logic signed [11:0] TOP12   = 12'(OBS_TOP);

  slot_t [NUM_SLOTS-1:0] r_slots, w_slots_nxt;
  spawn_state_e          r_state, w_state_nxt;
  logic [GAP_W-1:0]      r_gap, w_gap_nxt;

  logic [15:0]           w_lfsr;
  logic [7:0]            w_lfsr_unused;
  logic                  w_accept;

  logic signed [10:0]    w_moved_x [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  w_alive;
  logic [NUM_SLOTS-1:0]  w_hit;
  logic signed [11:0]    w_dx [NUM_SLOTS];
  logic signed [11:0]    w_dy;
  logic                  w_dy_in;
  logic                  w_any_free;
  logic [IDX_W-1:0]      w_free_idx;

  logic [7:0]            w_rom_nxt, r_rom;
  logic [2:0]            w_type_nxt, r_type;

  // Restart wins over a coincident tick, so it vetoes acceptance.
  assign w_accept      = i_frame_tick & i_game_active & ~i_restart;
  assign w_lfsr_unused = w_lfsr[15:8];

  obs_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_accept),
    .o_state(w_lfsr)
  );

  assign w_dy    = $signed({2'b00, i_vpos}) - TOP12;
  assign w_dy_in = !w_dy[11] && (w_dy < PIX12);

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    assign w_moved_x[g] = $signed(r_slots[g].x) - $signed({7'd0, i_speed});
    assign w_alive[g]   = r_slots[g].valid && (w_moved_x[g] > X_GONE);
    assign w_dx[g]      = $signed({2'b00, i_hpos}) - $signed({r_slots[g].x[10], r_slots[g].x});
    assign w_hit[g]     = r_slots[g].valid && !w_dx[g][11] && (w_dx[g] < PIX12) && w_dy_in;
  end

  // Lowest-index slot that is free after this tick's movement and expiry.
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!w_alive[i]) begin
        w_any_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  // Next slot/gap/FSM state: move and expire first, then attempt the spawn.
  always_comb begin
    w_slots_nxt = r_slots;
    w_gap_nxt   = r_gap;
    w_state_nxt = r_state;
    if (i_restart) begin
      w_slots_nxt = '0;
      w_gap_nxt   = GAP_W'(MIN_GAP);
      w_state_nxt = WAIT_GAP;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        w_slots_nxt[i].valid = w_alive[i];
        if (r_slots[i].valid) w_slots_nxt[i].x = w_moved_x[i];
      end
      case (r_state)
        WAIT_GAP: begin
          if (r_gap <= GAP_W'(1)) begin
            w_gap_nxt   = '0;
            w_state_nxt = SPAWN;
          end else begin
            w_gap_nxt = r_gap - 1'b1;
          end
        end
        SPAWN: begin
          // With every slot busy we keep retrying on later ticks.
          if (w_any_free) begin
            if (w_lfsr[2:0] != EMPTY)
              w_slots_nxt[w_free_idx] = '{valid: 1'b1, x: X_SPAWN, otype: w_lfsr[2:0]};
            w_gap_nxt   = GAP_W'(MIN_GAP) + GAP_W'(w_lfsr[7:3]);
            w_state_nxt = WAIT_GAP;
          end
        end
        default: w_state_nxt = WAIT_GAP;
      endcase
    end
  end

  // Pixel lookup: first covering slot by lowest index supplies the address.
  always_comb begin
    w_rom_nxt  = '0;
    w_type_nxt = EMPTY;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_rom_nxt  = {w_dy[SCALE_SHIFT +: 4], w_dx[i][SCALE_SHIFT +: 4]};
        w_type_nxt = r_slots[i].otype;
      end
    end
  end

  // Slot, gap counter and spawn FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slots <= '0;
      r_gap   <= GAP_W'(MIN_GAP);
      r_state <= WAIT_GAP;
    end else begin
      r_slots <= w_slots_nxt;
      r_gap   <= w_gap_nxt;
      r_state <= w_state_nxt;
    end
  end

  // One-cycle registered pixel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom  <= '0;
      r_type <= EMPTY;
    end else begin
      r_rom  <= w_rom_nxt;
      r_type <= w_type_nxt;
    end
  end

  assign o_rom_counter = r_rom;
  assign o_obs_type    = r_type;

endmodule
